// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one uart_tx core among NREQ requesters.
// A granted requester keeps the transmitter until it drops req or sends MAX_BURST bytes.
module uart_tx_sched #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     wr,
    input  logic [NREQ*8-1:0]   wr_data,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [2:0]          owner_id,
    output logic                busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_e;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_e                 state_q,      state_d;
    logic                   wait_first_q, wait_first_d;
    logic [NREQ-1:0]        gnt_q,        gnt_d;
    logic [NREQ-1:0]        ack_q,        ack_d;
    logic [IDX_W-1:0]       owner_q,      owner_d;
    logic                   busy_q,       busy_d;
    logic                   tx_start_q,   tx_start_d;
    logic [7:0]             tx_data_q,    tx_data_d;
    logic [CNT_W-1:0]       burst_cnt_q,  burst_cnt_d;
    logic [IDX_W-1:0]       last_owner_q, last_owner_d;

    logic [7:0]             wr_bytes [NREQ];
    logic [IDX_W-1:0]       winner;
    logic                   winner_vld;
    logic [IDX_W-1:0]       cand;
    int                     pos;
    logic                   burst_done;
    logic                   release_own;
    logic                   accept;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wr_bytes[i] = wr_data[i*8 +: 8];
        end
    end

    // Search starts just after the previous owner so it becomes lowest priority.
    always_comb begin
        winner     = '0;
        winner_vld = 1'b0;
        cand       = '0;
        pos        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = int'(last_owner_q) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            cand = IDX_W'(pos);
            if (!winner_vld && req[cand]) begin
                winner_vld = 1'b1;
                winner     = cand;
            end
        end
    end

    assign burst_done  = (burst_cnt_q == CNT_W'(MAX_BURST));
    assign release_own = (state_q == OWN) && (!req[owner_q] || burst_done);
    assign accept      = (state_q == OWN) && !release_own && wr[owner_q] && !tx_busy;

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // clears every flop so outputs drop the instant reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_first_q <= 1'b0;
            gnt_q        <= '0;
            ack_q        <= '0;
            owner_q      <= '0;
            busy_q       <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            burst_cnt_q  <= '0;
            last_owner_q <= IDX_W'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            wait_first_q <= wait_first_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        wait_first_d = (state_q == START);
        unique case (state_q)
            IDLE: begin
                if (winner_vld) begin
                    state_d = OWN;
                end
            end
            OWN: begin
                if (release_own) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                // tx_busy may still be low in the first WAIT cycle, so it is ignored there.
                if (!wait_first_q && !tx_busy) begin
                    state_d = OWN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d        = gnt_q;
        ack_d        = '0;
        owner_d      = owner_q;
        busy_d       = busy_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        if (state_q == IDLE && winner_vld) begin
            gnt_d       = onehot(winner);
            owner_d     = winner;
            busy_d      = 1'b1;
            burst_cnt_d = '0;
        end
        if (release_own) begin
            gnt_d        = '0;
            busy_d       = 1'b0;
            last_owner_d = owner_q;
        end
        if (accept) begin
            tx_data_d   = wr_bytes[owner_q];
            tx_start_d  = 1'b1;
            ack_d       = onehot(owner_q);
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign owner_id = 3'(owner_q);
    assign busy     = busy_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a small uart_tx busy model.
// Built with MAX_BURST=4 so the forced release is reachable in a short run.
module tb_uart_tx_sched;

    localparam int NREQ = 4;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    wr;
    logic [NREQ*8-1:0]  wr_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [2:0]         owner_id;
    logic               busy;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;

    int                 n_vec = 0;
    int                 n_err = 0;
    int                 inv_bad = 0;
    int                 tx_count = 0;
    logic [NREQ-1:0]    ack_seen = '0;
    int                 busy_len = 10;
    int                 model_cnt;

    uart_tx_sched #(.NREQ(NREQ), .MAX_BURST(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wr       (wr),
        .wr_data  (wr_data),
        .gnt      (gnt),
        .ack      (ack),
        .owner_id (owner_id),
        .busy     (busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx stand-in: busy from the cycle after tx_start for busy_len cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_cnt <= 0;
        end else if (tx_start) begin
            model_cnt <= busy_len;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
        end
    end
    assign tx_busy = (model_cnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!$onehot0(gnt) || ((ack & ~gnt) != '0) || (tx_start && tx_busy)) inv_bad++;
        if (tx_start) tx_count++;
        ack_seen |= ack;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        wr_data[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        wr    = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_tx_start(input string tag);
        int n;
        n = 0;
        while (!tx_start && n < 60) begin
            step();
            n++;
        end
        check(tag, tx_start, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 100);
        check(tag, busy, 0);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        int n;
        int ngr;
        int nb;
        int n2;
        int busy_cycles;
        int gated_bad;
        int tx_base;
        int exp_order [5];
        int got_order [5];
        int idle_before [5];
        logic [NREQ-1:0] prev_gnt;
        logic prev_busy;
        logic [NREQ-1:0] rearm;
        int exp_own [9];
        logic [7:0] exp_dat [9];
        int got_own [9];
        logic [7:0] got_dat [9];

        reset   = 1'b1;
        req     = '0;
        wr      = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_owner", owner_id, 0);
        reset = 1'b0;

        // Single requester, 10-cycle busy window, back-to-back second byte.
        busy_len = 10;
        step();
        req[0] = 1'b1;
        wr[0]  = 1'b1;
        set_byte(0, 8'h41);
        step();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_owner", owner_id, 0);
        check("t1_no_start", tx_start, 0);
        step();
        check("t1_start", tx_start, 1);
        check("t1_ack", ack, 4'b0001);
        check("t1_data", tx_data, 8'h41);
        set_byte(0, 8'h42);
        n = 0;
        do begin
            step();
            n++;
        end while (!tx_start && n < 40);
        check("t1_gap", n, 13);
        check("t1_data2", tx_data, 8'h42);
        check("t1_ack2", ack, 4'b0001);
        req = '0;
        wr  = '0;
        wait_idle("t1_idle");
        check("t1_gnt_off", gnt, 0);

        // Round-robin with one-byte packets from all four requesters.
        do_reset();
        busy_len = 3;
        for (int i = 0; i < NREQ; i++) set_byte(i, 8'hA0 + 8'(i));
        exp_order = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        wr  = 4'b1111;
        rearm = '0;
        ngr = 0;
        prev_gnt = '0;
        prev_busy = 1'b0;
        for (int cyc = 0; cyc < 300 && ngr < 5; cyc++) begin
            step();
            if (gnt != '0 && prev_gnt == '0) begin
                got_order[ngr]   = oh_idx(gnt);
                idle_before[ngr] = (prev_busy == 1'b0) ? 1 : 0;
                ngr++;
            end
            if (tx_start && ngr > 0) begin
                check("t2_data", tx_data, 8'hA0 + 8'(exp_order[ngr-1]));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    req[i]   = 1'b0;
                    wr[i]    = 1'b0;
                    rearm[i] = 1'b1;
                end else if (rearm[i] && !gnt[i]) begin
                    req[i]   = 1'b1;
                    wr[i]    = 1'b1;
                    rearm[i] = 1'b0;
                end
            end
            prev_gnt  = gnt;
            prev_busy = busy;
        end
        check("t2_ngrants", ngr, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < ngr) begin
                check($sformatf("t2_order%0d", k), got_order[k], exp_order[k]);
                check($sformatf("t2_idle%0d", k), idle_before[k], 1);
            end
        end
        req = '0;
        wr  = '0;
        wait_idle("t2_idle");

        // Burst limit: requester 2 sends 8 bytes, requester 3 interleaves after 4.
        do_reset();
        busy_len = 3;
        for (int k = 0; k < 4; k++) begin
            exp_own[k] = 2;
            exp_dat[k] = 8'h10 + 8'(k);
        end
        exp_own[4] = 3;
        exp_dat[4] = 8'h30;
        for (int k = 4; k < 8; k++) begin
            exp_own[k+1] = 2;
            exp_dat[k+1] = 8'h10 + 8'(k);
        end
        set_byte(2, 8'h10);
        set_byte(3, 8'h30);
        req = 4'b1100;
        wr  = 4'b1100;
        tx_base = tx_count;
        nb = 0;
        n2 = 0;
        for (int cyc = 0; cyc < 400 && nb < 9; cyc++) begin
            step();
            if (tx_start) begin
                got_own[nb] = int'(owner_id);
                got_dat[nb] = tx_data;
                nb++;
            end
            if (ack[2]) begin
                n2++;
                if (n2 == 8) begin
                    req[2] = 1'b0;
                    wr[2]  = 1'b0;
                end else begin
                    set_byte(2, 8'h10 + 8'(n2));
                end
            end
            if (ack[3]) begin
                req[3] = 1'b0;
                wr[3]  = 1'b0;
            end
        end
        check("t3_nbytes", nb, 9);
        for (int k = 0; k < 9; k++) begin
            if (k < nb) begin
                check($sformatf("t3_own%0d", k), got_own[k], exp_own[k]);
                check($sformatf("t3_dat%0d", k), got_dat[k], exp_dat[k]);
            end
        end
        req = '0;
        wr  = '0;
        wait_idle("t3_idle");
        check("t3_total_tx", tx_count - tx_base, 9);

        // Non-owner wr and tx_busy gating.
        do_reset();
        busy_len = 6;
        ack_seen = '0;
        set_byte(1, 8'h51);
        req[1] = 1'b1;
        wr[1]  = 1'b1;
        wait_tx_start("t4_first_start");
        check("t4_data1", tx_data, 8'h51);
        check("t4_ack1", ack, 4'b0010);
        set_byte(1, 8'h52);
        set_byte(0, 8'hEE);
        wr[0] = 1'b1;
        n = 0;
        busy_cycles = 0;
        gated_bad = 0;
        do begin
            step();
            n++;
            if (tx_busy) busy_cycles++;
            if (tx_busy && (ack != '0 || tx_start)) gated_bad++;
            wr[1] = tx_busy ? ~wr[1] : 1'b1;
            wr[0] = ~wr[0];
        end while (!tx_start && n < 40);
        check("t4_start2", tx_start, 1);
        check("t4_data2", tx_data, 8'h52);
        check("t4_ack2", ack, 4'b0010);
        check("t4_busy_cycles", busy_cycles, 6);
        check("t4_gated", gated_bad, 0);
        req[1] = 1'b0;
        wr[1]  = 1'b0;
        wr[0]  = 1'b1;
        wait_idle("t4_idle");
        repeat (3) step();
        check("t4_no_gnt", gnt, 0);
        check("t4_no_ack0", ack_seen[0], 0);
        wr = '0;

        // req dropped in the START cycle: byte completes, release after WAIT.
        do_reset();
        busy_len = 3;
        tx_base = tx_count;
        set_byte(1, 8'h61);
        req[1] = 1'b1;
        wr[1]  = 1'b1;
        wait_tx_start("t5_start");
        check("t5_data", tx_data, 8'h61);
        req = '0;
        wr  = '0;
        step();
        check("t5_inflight", tx_busy, 1);
        check("t5_busy_wait", busy, 1);
        repeat (3) step();
        step();
        check("t5_own_busy", busy, 1);
        check("t5_own_gnt", gnt, 4'b0010);
        step();
        check("t5_rel_busy", busy, 0);
        check("t5_rel_gnt", gnt, 0);
        check("t5_one_byte", tx_count - tx_base, 1);

        // Async reset while in WAIT.
        do_reset();
        busy_len = 8;
        set_byte(0, 8'h71);
        req[0] = 1'b1;
        wr[0]  = 1'b1;
        wait_tx_start("t6_start");
        step();
        step();
        check("t6_gnt_pre", gnt, 4'b0001);
        #3;
        reset = 1'b1;
        #1;
        check("t6_gnt", gnt, 0);
        check("t6_ack", ack, 0);
        check("t6_tx_start", tx_start, 0);
        check("t6_busy", busy, 0);
        check("t6_tx_data", tx_data, 8'h00);
        req = 4'b1001;
        wr  = 4'b1001;
        set_byte(3, 8'h73);
        #1;
        reset = 1'b0;
        step();
        check("t6_regnt", gnt, 4'b0001);
        check("t6_reowner", owner_id, 0);
        req = '0;
        wr  = '0;
        wait_idle("t6_idle");

        check("invariants", inv_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares the single UART transmitter among NREQ on-chip requesters, such as CPU debug print, a GPIO event logger and a DMA/trace source.
- Uses round-robin arbitration with packet locking: a granted requester owns the transmitter until it drops req or exhausts MAX_BURST bytes.
- Sits between the requesters and the existing uart_tx core, and drives that core's tx_start/tx_data inputs from its tx_busy output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 16, max bytes per grant before forced release (1..255).
- CNT_W, 8, width of burst counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  in  1  system clock (same domain as uart_tx).
- reset  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester channel request; level, held for the whole packet.
- wr  in  NREQ  per-requester byte valid; data must be held until ack.
- wr_data  in  NREQ*8  flattened bytes; requester i occupies bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant, registered.
- ack  out  NREQ  one-cycle pulse: byte from gnt owner accepted.
- owner_id  out  3  index of the current owner; valid while busy=1.
- busy  out  1  channel owned by some requester.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; held stable from tx_start until the next tx_start.
- tx_busy  in  1  uart_tx busy; contract: rises the cycle after tx_start is sampled, falls when the stop bit ends.

Behaviour:
- Reset (async, any state): state=IDLE; gnt=0, ack=0, tx_start=0, tx_data=8'h00, busy=0, owner_id=0, burst_cnt=0, last_owner=NREQ-1. Requester 0 therefore has first priority.
- All outputs are registered. FSM states: IDLE, OWN, START, WAIT.
- IDLE:
  - If req!=0, the winner is the first set bit searching from last_owner+1 upward with wrap.
  - Next cycle: gnt=onehot(winner), owner_id=winner, busy=1, burst_cnt=0, state=OWN.
  - Grant latency is 1 cycle from req sampled high.
- OWN (priority order):
  - (a) req[owner]==0: release; gnt=0, busy=0, last_owner=owner, state IDLE.
  - (b) burst_cnt==MAX_BURST: release identically, even if req is still high.
  - (c) wr[owner]==1 and tx_busy==0: tx_data=wr_data[owner], tx_start=1, ack[owner]=1, burst_cnt+1, state START.
  - (d) otherwise: hold.
- START: lasts exactly 1 cycle; tx_start and ack are high this cycle only; state moves to WAIT.
- WAIT:
  - tx_start=0, ack=0; the first WAIT cycle is not checked, because tx_busy may not yet be high.
  - From the second WAIT cycle on, tx_busy==0 moves the state to OWN.
- Releases return to IDLE for at least 1 cycle, so re-arbitration takes 2 cycles from release to the next gnt. The releasing requester gets lowest priority next round.
- wr from non-owners, and wr while not in OWN, are ignored without loss; the requester keeps wr high until ack.
- req dropped during START/WAIT: the in-flight byte completes and release happens at the next OWN.
- A back-to-back byte from the owner is accepted in the first OWN cycle after WAIT exits when wr is already high, so there are no gap cycles beyond the FSM hop.
- The forced release at MAX_BURST is evaluated only in OWN, so it always happens on a byte boundary; a byte is never truncated.
- Invariants:
  - gnt is one-hot or zero.
  - ack is a subset of gnt.
  - tx_start never asserts while tx_busy==1.
  - burst_cnt never exceeds MAX_BURST.
- Reset mid-byte: outputs clear immediately. The uart_tx is reset by the same reset, so no partial-frame handling is needed.

Test Plan:
- Single requester: reset released, req[0]=1, wr[0]=1, wr_data byte0=8'h41, uart model busy for 10 cycles -> gnt=4'b0001 one cycle after req; tx_start and ack[0] pulse together carrying 8'h41; no second tx_start until 1 cycle after tx_busy falls.
- Round-robin fairness: req=4'b1111 steady, each requester sending 1-byte packets (req drops after ack) -> grant order 0,1,2,3,0; each gnt is preceded by an IDLE cycle.
- Burst limit: MAX_BURST=4, req[2] held high with a continuous wr of 8 bytes 8'h10..8'h17, req[3] also high -> bytes 10..13 sent, release, requester 3 is granted, then requester 2 is re-granted and sends 14..17; no byte is lost or duplicated.
- Non-owner and busy gating: owner 1 mid-byte with tx_busy=1, while wr[0] and wr[1] pulse -> no ack and no tx_start until tx_busy=0; wr[0] is never acked while requester 0 does not own the channel.
- Release mid-byte: req[1] dropped in the START cycle -> the byte completes, then busy=0 and gnt=0 in the cycle after WAIT exits to OWN.
- Async reset in WAIT: reset asserted between clock edges -> gnt, ack, tx_start and busy are 0 immediately; after release, req=4'b1001 grants requester 0 first.
